// File: rtl/multimode_shift_register.sv
// Multimode shift register: immediate shift/rotate/load operations plus a
// one-bit-per-cycle burst mode driven by a small IDLE/RUN controller.
module multimode_shift_register #(
  parameter int N  = 8,
  parameter int AW = $clog2(N)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          en,
  input  logic [2:0]    op,
  input  logic [AW-1:0] amt,
  input  logic [N-1:0]  I,
  input  logic          MSB_in,
  input  logic          LSB_in,
  input  logic          start,
  output logic [N-1:0]  O,
  output logic          MSB_out,
  output logic          LSB_out,
  output logic          busy,
  output logic          done
);

  typedef enum logic {IDLE, RUN} state_t;

  localparam logic [2:0]    OP_HOLD = 3'b000;
  localparam logic [2:0]    OP_SHR  = 3'b001;
  localparam logic [2:0]    OP_SHL  = 3'b010;
  localparam logic [2:0]    OP_LOAD = 3'b011;
  localparam logic [2:0]    OP_ROR  = 3'b100;
  localparam logic [2:0]    OP_ROL  = 3'b101;
  localparam logic [2:0]    OP_ASR  = 3'b110;
  localparam logic [AW-1:0] AMT_ONE = AW'(1);

  state_t        state;
  logic [2:0]    op_q;
  logic [AW-1:0] cnt;
  logic [N-1:0]  o_q;
  logic          done_q;

  // Ops that move bits and can therefore be run as a burst.
  function automatic logic is_shift_op(input logic [2:0] code);
    logic r;
    case (code)
      OP_SHR, OP_SHL, OP_ROR, OP_ROL, OP_ASR: r = 1'b1;
      default:                                r = 1'b0;
    endcase
    return r;
  endfunction

  // Next register value for one operation; amt never exceeds N-1 by width.
  function automatic logic [N-1:0] apply_op(
    input logic [2:0]    code,
    input logic [N-1:0]  d,
    input logic [AW-1:0] sh,
    input logic          msb_fill,
    input logic          lsb_fill,
    input logic [N-1:0]  load
  );
    logic [N-1:0]   r;
    logic [N-1:0]   ones;
    logic [2*N-1:0] dbl;
    logic [2*N-1:0] tmp;
    logic signed [N-1:0] sd;
    ones = '1;
    dbl  = {d, d};
    tmp  = '0;
    sd   = $signed(d);
    r    = d;
    case (code)
      OP_SHR:  r = (d >> sh) | (msb_fill ? ~(ones >> sh) : '0);
      OP_SHL:  r = (d << sh) | (lsb_fill ? ~(ones << sh) : '0);
      OP_LOAD: r = load;
      OP_ROR: begin
        tmp = dbl >> sh;
        r   = tmp[N-1:0];
      end
      OP_ROL: begin
        tmp = dbl << sh;
        r   = tmp[2*N-1:N];
      end
      OP_ASR:  r = sd >>> sh;
      default: r = d;
    endcase
    return r;
  endfunction

  // Controller and data register: immediate ops in IDLE, single-bit steps in RUN.
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      op_q   <= OP_HOLD;
      cnt    <= '0;
      o_q    <= '0;
      done_q <= 1'b0;
    end else if (en) begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (start && is_shift_op(op)) begin
            // Burst request: the start edge itself only arms the counter.
            if (amt != '0) begin
              op_q  <= op;
              cnt   <= amt;
              state <= RUN;
            end else begin
              done_q <= 1'b1;
            end
          end else begin
            o_q <= apply_op(op, o_q, amt, MSB_in, LSB_in, I);
          end
        end
        RUN: begin
          o_q <= apply_op(op_q, o_q, AMT_ONE, MSB_in, LSB_in, I);
          cnt <= cnt - AMT_ONE;
          if (cnt == AMT_ONE) begin
            state  <= IDLE;
            done_q <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign O       = o_q;
  assign MSB_out = o_q[N-1];
  assign LSB_out = o_q[0];
  assign busy    = (state == RUN);
  assign done    = done_q;

endmodule

// File: tb/tb_multimode_shift_register.sv
// Self-checking bench for multimode_shift_register (N=8): directed scenarios
// plus randomized traffic compared against a bit-level behavioural model.
module tb_multimode_shift_register;

  localparam int N  = 8;
  localparam int AW = 3;

  logic          clk = 1'b0;
  logic          reset, en, start, MSB_in, LSB_in;
  logic [2:0]    op;
  logic [AW-1:0] amt;
  logic [N-1:0]  I;
  logic [N-1:0]  O;
  logic          MSB_out, LSB_out, busy, done;

  multimode_shift_register #(.N(N), .AW(AW)) dut (
    .clk(clk), .reset(reset), .en(en), .op(op), .amt(amt), .I(I),
    .MSB_in(MSB_in), .LSB_in(LSB_in), .start(start),
    .O(O), .MSB_out(MSB_out), .LSB_out(LSB_out), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model state
  logic [N-1:0] m_o;
  bit           m_busy;
  bit           m_done;
  int           m_rem;
  logic [2:0]   m_op;
  int           dcount;
  int           bcount;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Bit-by-bit definition of every operation.
  function automatic logic [N-1:0] ref_op(input logic [2:0] code, input logic [N-1:0] v,
                                          input int k, input bit mi, input bit li,
                                          input logic [N-1:0] ld);
    logic [N-1:0] r;
    r = v;
    for (int i = 0; i < N; i++) begin
      case (code)
        3'd1: r[i] = (i + k < N) ? v[i + k] : mi;
        3'd2: r[i] = (i >= k) ? v[i - k] : li;
        3'd3: r[i] = ld[i];
        3'd4: r[i] = v[(i + k) % N];
        3'd5: r[i] = v[(i - k + N) % N];
        3'd6: r[i] = (i + k < N) ? v[i + k] : v[N-1];
        default: r[i] = v[i];
      endcase
    end
    return r;
  endfunction

  function automatic bit burstable(input logic [2:0] code);
    return (code == 3'd1) || (code == 3'd2) || (code == 3'd4) || (code == 3'd5) || (code == 3'd6);
  endfunction

  task automatic model_edge();
    if (reset) begin
      m_o = '0; m_busy = 0; m_done = 0; m_rem = 0;
    end else if (en) begin
      m_done = 0;
      if (m_busy) begin
        m_o = ref_op(m_op, m_o, 1, MSB_in, LSB_in, I);
        m_rem--;
        if (m_rem == 0) begin
          m_busy = 0;
          m_done = 1;
        end
      end else if (start && burstable(op)) begin
        if (int'(amt) > 0) begin
          m_op = op; m_rem = int'(amt); m_busy = 1;
        end else begin
          m_done = 1;
        end
      end else begin
        m_o = ref_op(op, m_o, int'(amt), MSB_in, LSB_in, I);
      end
    end
  endtask

  // One clock: model follows the edge, outputs compared at the falling edge.
  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_eq("O", 32'(O), 32'(m_o));
    check_eq("busy", 32'(busy), 32'(m_busy));
    check_eq("done", 32'(done), 32'(m_done));
    check_eq("MSB_out", 32'(MSB_out), 32'(m_o[N-1]));
    check_eq("LSB_out", 32'(LSB_out), 32'(m_o[0]));
    if (done) dcount++;
    if (busy) bcount++;
  endtask

  task automatic load(input logic [N-1:0] v);
    op = 3'd3; I = v; start = 0;
    tick();
  endtask

  initial begin
    m_o = '0; m_busy = 0; m_done = 0; m_rem = 0; m_op = '0;
    dcount = 0; bcount = 0;
    reset = 1; en = 0; start = 1; op = 3'd3; amt = '0; I = 8'hFF; MSB_in = 0; LSB_in = 0;
    @(negedge clk);
    tick();
    check_eq("reset_O", 32'(O), 32'h0);
    check_eq("reset_busy", 32'(busy), 32'h0);
    reset = 0; en = 1; start = 0;

    // Load and rotate
    load(8'hA5);
    check_eq("load_A5", 32'(O), 32'hA5);
    op = 3'd4; amt = 3; tick();
    check_eq("ror3", 32'(O), 32'hB4);
    op = 3'd5; amt = 3; tick();
    check_eq("rol3", 32'(O), 32'hA5);

    // Fill and sign
    load(8'h90); op = 3'd6; amt = 2; tick();
    check_eq("asr2", 32'(O), 32'hE4);
    load(8'h90); op = 3'd1; amt = 2; MSB_in = 1; tick();
    check_eq("shr2_fill1", 32'(O), 32'hE4);
    load(8'h90); op = 3'd2; amt = 4; LSB_in = 0; MSB_in = 0; tick();
    check_eq("shl4", 32'(O), 32'h00);
    load(8'h5A); op = 3'd4; amt = 0; tick();
    check_eq("ror0", 32'(O), 32'h5A);

    // Burst with a two-cycle stall, and a done pulse delayed by en=0
    load(8'h01);
    start = 1; op = 3'd2; amt = 3; LSB_in = 1; tick();
    check_eq("burst_arm_O", 32'(O), 32'h01);
    check_eq("burst_arm_busy", 32'(busy), 32'h1);
    start = 0; op = 3'd0; tick();
    en = 0; tick(); tick();
    check_eq("stall_O", 32'(O), 32'h03);
    check_eq("stall_busy", 32'(busy), 32'h1);
    en = 1; tick(); tick();
    check_eq("burst_O", 32'(O), 32'h0F);
    check_eq("burst_done", 32'(done), 32'h1);
    en = 0; tick();
    check_eq("done_held", 32'(done), 32'h1);
    en = 1; tick();
    check_eq("done_clear", 32'(done), 32'h0);

    // Busy rejection: second start with a load during the burst
    load(8'h3C); dcount = 0;
    start = 1; op = 3'd4; amt = 4; tick();
    op = 3'd3; I = 8'hFF; tick(); tick();
    start = 0; op = 3'd0;
    for (int i = 0; i < 6; i++) tick();
    check_eq("reject_O", 32'(O), 32'hC3);
    check_eq("reject_dones", 32'(dcount), 32'd1);

    // Reset on the second RUN cycle
    load(8'h81); dcount = 0;
    start = 1; op = 3'd1; amt = 5; MSB_in = 0; tick();
    start = 0; op = 3'd0; tick();
    reset = 1; tick();
    check_eq("rst_mid_O", 32'(O), 32'h0);
    check_eq("rst_mid_busy", 32'(busy), 32'h0);
    reset = 0;
    for (int i = 0; i < 6; i++) tick();
    check_eq("rst_mid_dones", 32'(dcount), 32'd0);

    // Zero-length burst
    load(8'h77); dcount = 0; bcount = 0;
    start = 1; op = 3'd4; amt = 0; tick();
    check_eq("zero_done", 32'(done), 32'h1);
    start = 0; op = 3'd0; tick(); tick();
    check_eq("zero_O", 32'(O), 32'h77);
    check_eq("zero_dones", 32'(dcount), 32'd1);
    check_eq("zero_busy_cnt", 32'(bcount), 32'd0);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      reset  = ($urandom_range(0, 99) < 2);
      en     = ($urandom_range(0, 99) < 80);
      start  = ($urandom_range(0, 99) < 25);
      op     = 3'($urandom_range(0, 7));
      amt    = AW'($urandom_range(0, N-1));
      I      = N'($urandom);
      MSB_in = 1'($urandom_range(0, 1));
      LSB_in = 1'($urandom_range(0, 1));
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
